// File: rtl/power_sum_acc.sv
// Iterative power-series accumulator: S = sum_{k=1..n} k^p, one term per clock.
// Host handshake: start is taken whenever busy is low; valid pulses once when S is final.
module power_sum_acc #(
   parameter int N_W   = 4,
   parameter int SUM_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_W-1:0]   order,
   input  logic [1:0]       mode,
   output logic             busy,
   output logic             valid,
   output logic [SUM_W-1:0] sum,
   output logic             ovf,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int T_W   = 3 * N_W;
   localparam int ADD_W = ((SUM_W > T_W) ? SUM_W : T_W) + 1;

   state_t             state;
   logic [N_W:0]       k;
   logic [N_W-1:0]     n_q;
   logic [1:0]         p_q;
   logic [T_W-1:0]     k_ext;
   logic [T_W-1:0]     term;
   logic [ADD_W-1:0]   sum_full;
   logic               sat_hit;

   // k never exceeds 2^N_W-1 while a term is being added, so k^3 fits in 3*N_W bits.
   always_comb begin
      k_ext = T_W'(k);
      term  = '0;
      case (p_q)
         2'd0:    term = T_W'(1);
         2'd1:    term = k_ext;
         2'd2:    term = k_ext * k_ext;
         default: term = k_ext * k_ext * k_ext;
      endcase
      sum_full = ADD_W'(sum) + ADD_W'(term);
      sat_hit  = sum_full > ADD_W'({SUM_W{1'b1}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         k     <= '0;
         n_q   <= '0;
         p_q   <= '0;
         sum   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               k <= k + 1'b1;
               // Every term is >= 1, so a saturated sum keeps re-saturating until restart.
               if (sat_hit) begin
                  sum <= '1;
                  ovf <= 1'b1;
               end else begin
                  sum <= sum_full[SUM_W-1:0];
               end
               if (k == {1'b0, n_q}) state <= DONE;
            end
            default: begin
               if (start) begin
                  n_q   <= order;
                  p_q   <= mode;
                  sum   <= '0;
                  ovf   <= 1'b0;
                  k     <= (N_W+1)'(1);
                  state <= (order != '0) ? RUN : DONE;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign busy      = (state == RUN);
   assign valid     = (state == DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_power_sum_acc.sv
// Bench for power_sum_acc: a 16-bit and an 8-bit sum instance share stimulus and are
// checked every cycle against a job-level model (terms added so far, closed-form sums).
module tb_power_sum_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  order = '0;
   logic [1:0]  mode = '0;
   logic        busy16, valid16, ovf16, busy8, valid8, ovf8;
   logic [15:0] sum16;
   logic [7:0]  sum8;
   logic [1:0]  st16, st8;

   int tests = 0;
   int fails = 0;
   bit noise_en = 1'b0;

   power_sum_acc #(.N_W(4), .SUM_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .order(order), .mode(mode),
      .busy(busy16), .valid(valid16), .sum(sum16), .ovf(ovf16), .dbg_state(st16)
   );

   power_sum_acc #(.N_W(4), .SUM_W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .order(order), .mode(mode),
      .busy(busy8), .valid(valid8), .sum(sum8), .ovf(ovf8), .dbg_state(st8)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout act=running req=finished");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   bit m_running = 1'b0;
   bit m_valid   = 1'b0;
   int m_n = 0;
   int m_p = 0;
   int m_j = 0;

   function automatic longint raw_sum(int j, int p);
      longint s = 0;
      for (int kk = 1; kk <= j; kk++) begin
         longint t = 1;
         for (int e = 0; e < p; e++) t = t * kk;
         s += t;
      end
      return s;
   endfunction

   function automatic longint sat_sum(int j, int p, int w);
      longint mx = (longint'(1) << w) - 1;
      longint s = raw_sum(j, p);
      return (s > mx) ? mx : s;
   endfunction

   function automatic longint sat_ovf(int j, int p, int w);
      longint mx = (longint'(1) << w) - 1;
      return (raw_sum(j, p) > mx) ? 1 : 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_running = 1'b0; m_valid = 1'b0; m_n = 0; m_p = 0; m_j = 0;
      end else if (m_running) begin
         m_j++;
         if (m_j == m_n) begin
            m_running = 1'b0;
            m_valid   = 1'b1;
         end
      end else if (start) begin
         m_n = int'(order); m_p = int'(mode); m_j = 0;
         m_running = (order != 0);
         m_valid   = (order == 0);
      end else begin
         m_valid = 1'b0;
      end
   end

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s t=%0t act=%0d req=%0d", name, $time, act, req);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      check("busy16",  busy16,  m_running);
      check("valid16", valid16, m_valid);
      check("sum16",   sum16,   sat_sum(m_j, m_p, 16));
      check("ovf16",   ovf16,   sat_ovf(m_j, m_p, 16));
      check("busy8",   busy8,   m_running);
      check("valid8",  valid8,  m_valid);
      check("sum8",    sum8,    sat_sum(m_j, m_p, 8));
      check("ovf8",    ovf8,    sat_ovf(m_j, m_p, 8));
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge: drive a one-cycle start, return at the next negedge.
   task automatic start_job(input int n, input int p);
      start = 1'b1;
      order = 4'(n);
      mode  = 2'(p);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input int bound, input bit chk, input longint req16);
      bit found = 1'b0;
      for (int i = 0; i <= bound; i++) begin
         if (valid16) begin
            found = 1'b1;
            break;
         end
         if (noise_en && busy16) begin
            start = 1'($urandom_range(0, 1));
            order = 4'($urandom);
            mode  = 2'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (!found) check("valid_timeout", 0, 1);
      else if (chk) check("job_sum16", sum16, req16);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Pin the model with hand-computed series values.
      check("model_p2_n4",  raw_sum(4, 2), 30);
      check("model_p3_n15", raw_sum(15, 3), 14400);
      check("model_p1_n15", raw_sum(15, 1), 120);
      check("model_p2_n8",  raw_sum(8, 2), 204);
      check("model_p2_n9",  raw_sum(9, 2), 285);
      check("model_sat8",   sat_sum(15, 2, 8), 255);

      repeat (2) @(negedge clk);
      check("rst_sum16", sum16, 0);
      check("rst_busy",  busy16, 0);
      rst = 1'b0;
      @(negedge clk);

      // squares to 4: partial sums 1,5,14,30
      start_job(4, 2);
      wait_valid(10, 1'b1, 30);
      @(negedge clk);

      // cubes to 15
      start_job(15, 3);
      wait_valid(20, 1'b1, 14400);
      check("cubes_ovf16", ovf16, 0);
      @(negedge clk);

      // linear to 15, then back-to-back constant job started in the DONE cycle
      start_job(15, 1);
      wait_valid(20, 1'b1, 120);
      start_job(9, 0);
      wait_valid(15, 1'b1, 9);
      @(negedge clk);

      // order 0: valid right after the start edge, never busy
      start_job(0, 3);
      check("n0_valid", valid16, 1);
      check("n0_busy",  busy16, 0);
      wait_valid(2, 1'b1, 0);
      @(negedge clk);

      // 8-bit saturation, then a fresh job clears ovf
      start_job(15, 2);
      wait_valid(20, 1'b1, 1240);
      check("sat8_sum", sum8, 255);
      check("sat8_ovf", ovf8, 1);
      repeat (2) @(negedge clk);
      check("sat8_held", sum8, 255);
      start_job(3, 2);
      wait_valid(10, 1'b1, 14);
      check("fresh8_sum", sum8, 14);
      check("fresh8_ovf", ovf8, 0);
      @(negedge clk);

      // start/order noise during RUN, then an async reset pulse mid-run
      start_job(10, 2);
      repeat (3) begin
         start = 1'b1;
         order = 4'($urandom);
         mode  = 2'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_sum",  sum16, 0);
      check("async_rst_busy", busy16, 0);
      #1 rst = 1'b0;
      @(negedge clk);
      start_job(5, 3);
      wait_valid(10, 1'b1, 225);
      @(negedge clk);

      // randomized jobs with start/order/mode noise while busy
      noise_en = 1'b1;
      repeat (40) begin
         repeat ($urandom_range(0, 3)) begin
            order = 4'($urandom);
            mode  = 2'($urandom);
            @(negedge clk);
         end
         start_job($urandom_range(0, 15), $urandom_range(0, 3));
         wait_valid(20, 1'b0, 0);
         @(negedge clk);
      end
      noise_en = 1'b0;

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
